hazard_stall_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage core. It decides every cycle whether the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers advance, hold, take a bubble or get flushed. It covers RAW data hazards, load-use hazards, taken-branch flushes and multi-cycle data-memory waits. It sits beside the ID/EXE register and drives its bubble and flush controls, plus the freeze and bubble controls of the other stages.

---
 rtl/hazard_stall_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl
//   Pipeline sequencing controller for the 5-stage core. Each cycle it
//   decides whether the IF/ID, ID/EXE, EXE/MEM and MEM/WB registers advance,
//   hold, take a bubble or are flushed. It handles RAW hazards, load-use
//   hazards, taken-branch flushes and multi-cycle data-memory waits.
//
//   Parameters
//     FWD_EN   1 = forwarding present (stall on load-use only),
//              0 = stall on any RAW against EXE or MEM
//     MAX_WAIT MEM_WAIT cycles without mem_ready before mem_timeout sets
//
//   Ports
//     clock, reset          rising-edge clock, async active-high reset
//     id_*                  ID-stage instruction sources
//     exe_*, mem_*          destinations / write enables of EXE and MEM
//     branch_taken          EXE resolved a taken branch
//     mem_req, mem_ready    data-memory handshake of the MEM stage
//     perf_clear            synchronous clear of the perf counters
//     *_freeze/_bubble/_flush  combinational pipeline-register controls
//     state                 0 = RUN, 1 = MEM_WAIT
//     mem_timeout           sticky memory-timeout error
//     stall_cycles, flush_count  saturating performance counters
module hazard_stall_ctrl #(
  parameter bit          FWD_EN   = 1'b1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  input  logic [4:0]  id_src1,
  input  logic [4:0]  id_src2,
  input  logic        id_uses_src2,
  input  logic [4:0]  exe_dest,
  input  logic        exe_wb_en,
  input  logic        exe_mem_read,
  input  logic [4:0]  mem_dest,
  input  logic        mem_wb_en,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  input  logic        perf_clear,
  output logic        pc_freeze,
  output logic        ifid_freeze,
  output logic        idexe_bubble,
  output logic        idexe_freeze,
  output logic        exemem_freeze,
  output logic        memwb_bubble,
  output logic        ifid_flush,
  output logic        idexe_flush,
  output logic        state,
  output logic        mem_timeout,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] MAX_WAIT_L = 8'(MAX_WAIT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;
  logic [15:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  logic frozen, exe_hz, mem_hz, hazard, stall, flush;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  always_comb begin
    frozen = ((state_q == RUN) && mem_req && !mem_ready) ||
             ((state_q == MEM_WAIT) && !mem_ready);

    // Register 0 is hardwired; a write to it never creates a dependency.
    exe_hz = id_valid && exe_wb_en && (exe_dest != 5'd0) &&
             ((exe_dest == id_src1) || (id_uses_src2 && (exe_dest == id_src2)));
    mem_hz = id_valid && mem_wb_en && (mem_dest != 5'd0) &&
             ((mem_dest == id_src1) || (id_uses_src2 && (mem_dest == id_src2)));

    if (FWD_EN) hazard = exe_hz && exe_mem_read;
    else        hazard = exe_hz || mem_hz;

    // Memory wait dominates; a held branch_taken flushes once unfrozen.
    flush = branch_taken && !frozen;
    stall = hazard && !frozen && !branch_taken;

    state_d = state_q;
    case (state_q)
      RUN:      if (mem_req && !mem_ready) state_d = MEM_WAIT;
      MEM_WAIT: if (mem_ready)             state_d = RUN;
      default:                             state_d = RUN;
    endcase

    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    if (state_q == RUN) begin
      wait_cnt_d = '0;
    end else if (!mem_ready) begin
      if (wait_cnt_q != 8'hFF) wait_cnt_d = wait_cnt_q + 8'd1;
      if (wait_cnt_d >= MAX_WAIT_L) mem_timeout_d = 1'b1;
    end

    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (perf_clear) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if ((frozen || stall) && (stall_cycles_q != 16'hFFFF))
        stall_cycles_d = stall_cycles_q + 16'd1;
      if (flush && (flush_count_q != 16'hFFFF))
        flush_count_d = flush_count_q + 16'd1;
    end

    pc_freeze     = frozen || stall;
    ifid_freeze   = frozen || stall;
    idexe_bubble  = stall;
    idexe_freeze  = frozen;
    exemem_freeze = frozen;
    memwb_bubble  = frozen;
    ifid_flush    = flush;
    idexe_flush   = flush;
  end

  assign state        = state_q;
  assign mem_timeout  = mem_timeout_q;
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl. Two instances share the stimulus:
// u_fwd (FWD_EN=1) and u_nofwd (FWD_EN=0), both with MAX_WAIT=4.
// Control outputs are packed as
// {pc_freeze, ifid_freeze, idexe_bubble, idexe_freeze,
//  exemem_freeze, memwb_bubble, ifid_flush, idexe_flush}.
module tb_hazard_stall_ctrl;

  localparam logic [7:0] C_NONE   = 8'b0000_0000;
  localparam logic [7:0] C_STALL  = 8'b1110_0000;
  localparam logic [7:0] C_FROZEN = 8'b1101_1100;
  localparam logic [7:0] C_FLUSH  = 8'b0000_0011;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_src2, exe_wb_en, exe_mem_read, mem_wb_en;
  logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
  logic       branch_taken, mem_req, mem_ready, perf_clear;

  logic        f_pcf, f_iff, f_ieb, f_ief, f_emf, f_mwb, f_ifl, f_iel;
  logic        f_state, f_to;
  logic [15:0] f_stall, f_flush;
  logic        n_pcf, n_iff, n_ieb, n_ief, n_emf, n_mwb, n_ifl, n_iel;
  logic        n_state, n_to;
  logic [15:0] n_stall, n_flush;
  logic [7:0]  f_ctl, n_ctl;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  hazard_stall_ctrl #(.FWD_EN(1'b1), .MAX_WAIT(4)) u_fwd (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_uses_src2(id_uses_src2), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .perf_clear(perf_clear),
    .pc_freeze(f_pcf), .ifid_freeze(f_iff), .idexe_bubble(f_ieb),
    .idexe_freeze(f_ief), .exemem_freeze(f_emf), .memwb_bubble(f_mwb),
    .ifid_flush(f_ifl), .idexe_flush(f_iel), .state(f_state),
    .mem_timeout(f_to), .stall_cycles(f_stall), .flush_count(f_flush)
  );

  hazard_stall_ctrl #(.FWD_EN(1'b0), .MAX_WAIT(4)) u_nofwd (
    .clock(clock), .reset(reset), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_uses_src2(id_uses_src2), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_read(exe_mem_read), .mem_dest(mem_dest),
    .mem_wb_en(mem_wb_en), .branch_taken(branch_taken), .mem_req(mem_req),
    .mem_ready(mem_ready), .perf_clear(perf_clear),
    .pc_freeze(n_pcf), .ifid_freeze(n_iff), .idexe_bubble(n_ieb),
    .idexe_freeze(n_ief), .exemem_freeze(n_emf), .memwb_bubble(n_mwb),
    .ifid_flush(n_ifl), .idexe_flush(n_iel), .state(n_state),
    .mem_timeout(n_to), .stall_cycles(n_stall), .flush_count(n_flush)
  );

  assign f_ctl = {f_pcf, f_iff, f_ieb, f_ief, f_emf, f_mwb, f_ifl, f_iel};
  assign n_ctl = {n_pcf, n_iff, n_ieb, n_ief, n_emf, n_mwb, n_ifl, n_iel};

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_src1 = 0; id_src2 = 0; id_uses_src2 = 0;
    exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0;
    mem_dest = 0; mem_wb_en = 0;
    branch_taken = 0; mem_req = 0; mem_ready = 0; perf_clear = 0;
  endtask

  task automatic clear_counters();
    idle();
    perf_clear = 1;
    tick();
    perf_clear = 0;
  endtask

  task automatic load_use();
    id_valid = 1; id_src1 = 5; exe_dest = 5; exe_wb_en = 1; exe_mem_read = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1;
    #3;
    chk("reset_ctl",   {8'h00, f_ctl}, {8'h00, C_NONE});
    chk("reset_state", {15'd0, f_state}, 16'd0);
    chk("reset_to",    {15'd0, f_to}, 16'd0);
    chk("reset_stall", f_stall, 16'd0);
    chk("reset_flush", f_flush, 16'd0);
    @(negedge clock);
    reset = 0;
    tick();

    // Load-use: one stall cycle, then the load sits in MEM.
    load_use();
    #1;
    chk("lu_fwd_ctl",   {8'h00, f_ctl}, {8'h00, C_STALL});
    chk("lu_nofwd_ctl", {8'h00, n_ctl}, {8'h00, C_STALL});
    tick();
    exe_dest = 0; exe_wb_en = 0; exe_mem_read = 0;
    mem_dest = 5; mem_wb_en = 1;
    #1;
    chk("lu_fwd_stall_cnt", f_stall, 16'd1);
    chk("lu_fwd_after",     {8'h00, f_ctl}, {8'h00, C_NONE});
    chk("lu_nofwd_memraw",  {8'h00, n_ctl}, {8'h00, C_STALL});
    tick();
    idle();
    #1;
    chk("lu_fwd_stall_hold", f_stall, 16'd1);
    chk("lu_nofwd_stall",    n_stall, 16'd2);

    // Register 0 and invalid ID never stall.
    load_use(); exe_dest = 0; id_src1 = 0;
    #1;
    chk("r0_fwd",   {8'h00, f_ctl}, {8'h00, C_NONE});
    chk("r0_nofwd", {8'h00, n_ctl}, {8'h00, C_NONE});
    load_use(); id_valid = 0;
    #1;
    chk("novalid_fwd", {8'h00, f_ctl}, {8'h00, C_NONE});
    // Non-load EXE producer: forwarding covers it, no-forwarding stalls.
    load_use(); exe_mem_read = 0;
    #1;
    chk("alu_fwd",   {8'h00, f_ctl}, {8'h00, C_NONE});
    chk("alu_nofwd", {8'h00, n_ctl}, {8'h00, C_STALL});

    // No-forwarding RAW on src2.
    clear_counters();
    mem_wb_en = 1; mem_dest = 7; id_valid = 1; id_src1 = 3; id_src2 = 7; id_uses_src2 = 0;
    #1;
    chk("raw_src2_unused", {8'h00, n_ctl}, {8'h00, C_NONE});
    id_uses_src2 = 1;
    #1;
    chk("raw_src2_used",  {8'h00, n_ctl}, {8'h00, C_STALL});
    chk("raw_src2_fwd",   {8'h00, f_ctl}, {8'h00, C_NONE});
    tick();
    idle();
    #1;
    chk("raw_nofwd_cnt", n_stall, 16'd1);
    chk("raw_fwd_cnt",   f_stall, 16'd0);

    // Branch beats a load-use hazard.
    clear_counters();
    load_use(); branch_taken = 1;
    #1;
    chk("br_ctl", {8'h00, f_ctl}, {8'h00, C_FLUSH});
    tick();
    idle();
    #1;
    chk("br_flush_cnt", f_flush, 16'd1);
    chk("br_stall_cnt", f_stall, 16'd0);

    // Memory wait, mem_ready three cycles after mem_req.
    clear_counters();
    mem_req = 1;
    #1;
    chk("mw_c0_ctl",   {8'h00, f_ctl}, {8'h00, C_FROZEN});
    chk("mw_c0_state", {15'd0, f_state}, 16'd0);
    tick();
    #1;
    chk("mw_c1_ctl",   {8'h00, f_ctl}, {8'h00, C_FROZEN});
    chk("mw_c1_state", {15'd0, f_state}, 16'd1);
    tick();
    #1;
    chk("mw_c2_ctl",   {8'h00, f_ctl}, {8'h00, C_FROZEN});
    tick();
    mem_ready = 1;
    #1;
    chk("mw_ready_ctl",   {8'h00, f_ctl}, {8'h00, C_NONE});
    chk("mw_ready_state", {15'd0, f_state}, 16'd1);
    chk("mw_stall_cnt",   f_stall, 16'd3);
    tick();
    idle();
    #1;
    chk("mw_back_run", {15'd0, f_state}, 16'd0);
    chk("mw_cnt_hold", f_stall, 16'd3);
    // Same-cycle ready: no freeze, no state change.
    mem_req = 1; mem_ready = 1;
    #1;
    chk("mw_fast_ctl", {8'h00, f_ctl}, {8'h00, C_NONE});
    tick();
    idle();
    #1;
    chk("mw_fast_state", {15'd0, f_state}, 16'd0);
    chk("mw_fast_cnt",   f_stall, 16'd3);

    // Branch held across a 2-cycle memory wait flushes once.
    clear_counters();
    branch_taken = 1; mem_req = 1;
    #1;
    chk("df_c0_ctl", {8'h00, f_ctl}, {8'h00, C_FROZEN});
    tick();
    #1;
    chk("df_c1_ctl", {8'h00, f_ctl}, {8'h00, C_FROZEN});
    tick();
    mem_ready = 1;
    #1;
    chk("df_ready_ctl", {8'h00, f_ctl}, {8'h00, C_FLUSH});
    tick();
    idle();
    #1;
    chk("df_flush_cnt", f_flush, 16'd1);
    chk("df_stall_cnt", f_stall, 16'd2);

    // Timeout after four MEM_WAIT cycles, then async reset mid-wait.
    mem_req = 1;
    tick();
    tick(); tick(); tick();
    #1;
    chk("to_before", {15'd0, f_to}, 16'd0);
    tick();
    #1;
    chk("to_set", {15'd0, f_to}, 16'd1);
    tick();
    #1;
    chk("to_sticky", {15'd0, f_to}, 16'd1);
    chk("to_state",  {15'd0, f_state}, 16'd1);
    chk("to_frozen", {8'h00, f_ctl}, {8'h00, C_FROZEN});
    chk("to_nofwd",  {15'd0, n_to}, 16'd1);
    mem_req = 0;
    reset = 1;
    #1;
    chk("rst_state", {15'd0, f_state}, 16'd0);
    chk("rst_to",    {15'd0, f_to}, 16'd0);
    chk("rst_ctl",   {8'h00, f_ctl}, {8'h00, C_NONE});
    @(negedge clock);
    reset = 0;
    tick();

    // Saturation and perf_clear priority.
    load_use();
    force u_fwd.stall_cycles_q = 16'hFFFF;
    #1;
    release u_fwd.stall_cycles_q;
    #1;
    chk("sat_forced", f_stall, 16'hFFFF);
    tick();
    #1;
    chk("sat_hold1", f_stall, 16'hFFFF);
    tick();
    #1;
    chk("sat_hold2", f_stall, 16'hFFFF);
    perf_clear = 1;
    tick();
    #1;
    chk("clr_priority", f_stall, 16'd0);
    perf_clear = 0;
    tick();
    #1;
    chk("clr_count_again", f_stall, 16'd1);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
